winograd_post_transform_2d: RTL and testbench

// - Sequential 2-D Winograd output transform F(4x4,3x3): Y = A^T * M * A, M a 6x6 tile of 64-bit products.
// - Sits between the elementwise-product/accumulate stage (upstream) and the output-tile writer (downstream).
// - Accepts M one row per handshake and applies the 1-D A^T kernel to rows, then to columns.
// - Emits the 4x4 result one row per handshake.

---
 rtl/winograd_pkg.sv | 16 +
 rtl/Winograd_Post_Transform_1D.sv | 22 ++
 rtl/winograd_post_transform_2d.sv | 97 +++++++++
 tb/tb_winograd_post_transform_2d.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd F(4x4,3x3) output-transform blocks.
package winograd_pkg;

  localparam int unsigned TILE_IN  = 6;
  localparam int unsigned TILE_OUT = 4;
  localparam int unsigned DATA_W   = 64;

  typedef logic signed [DATA_W-1:0] wg_word_t;

  typedef enum logic [1:0] {
    LOAD,
    COL,
    OUT
  } post2d_state_t;

endpackage

// File: rtl/Winograd_Post_Transform_1D.sv
// Combinational 1-D Winograd output transform y = A^T * d for F(4,3); all arithmetic wraps mod 2^64.
module Winograd_Post_Transform_1D
  import winograd_pkg::*;
(
  input  wg_word_t [TILE_IN-1:0]  d,
  output wg_word_t [TILE_OUT-1:0] y
);

  wg_word_t s12, d12, s34, d34;

  always_comb begin
    s12  = d[1] + d[2];
    d12  = d[1] - d[2];
    s34  = d[3] + d[4];
    d34  = d[3] - d[4];
    y[0] = d[0] + s12 + s34;
    y[1] = d12 + (d34 << 1);
    y[2] = s12 + (s34 << 2);
    y[3] = d12 + (d34 << 3) + d[5];
  end

endmodule

// File: rtl/winograd_post_transform_2d.sv
// Sequential 2-D Winograd output transform Y = A^T * M * A: row pass on load, one column per cycle,
// then the 4x4 result is streamed out one row per handshake.
module winograd_post_transform_2d #(
  parameter int unsigned DATA_W = 64
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [winograd_pkg::TILE_IN-1:0][DATA_W-1:0]     in_row,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [winograd_pkg::TILE_OUT-1:0][DATA_W-1:0]    out_row,
  output logic                                             out_last,
  output logic                                             busy
);
  import winograd_pkg::*;

  post2d_state_t state_q, state_d;
  logic [2:0]    row_q;
  logic [1:0]    col_q, out_q;
  logic          last_row;

  wg_word_t [TILE_OUT-1:0] t_q [TILE_IN];
  wg_word_t [TILE_OUT-1:0] y_q [TILE_OUT];
  wg_word_t [TILE_OUT-1:0] row_res, col_res;
  wg_word_t [TILE_IN-1:0]  col_in;

  Winograd_Post_Transform_1D u_row_pass (
    .d (in_row),
    .y (row_res)
  );

  Winograd_Post_Transform_1D u_col_pass (
    .d (col_in),
    .y (col_res)
  );

  always_comb begin
    col_in = '0;
    for (int r = 0; r < TILE_IN; r++) begin
      col_in[r] = t_q[r][col_q];
    end
  end

  assign last_row = (row_q == 3'(TILE_IN - 1));
  assign busy     = !(state_q == LOAD && row_q == 3'd0);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_row   = '0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_row) state_d = COL;
      end
      COL: begin
        if (col_q == 2'(TILE_OUT - 1)) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_row   = y_q[out_q];
        out_last  = (out_q == 2'(TILE_OUT - 1));
        if (out_ready && out_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Counters wrap to zero naturally at the end of each phase, so LOAD always restarts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      row_q   <= '0;
      col_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_ready && in_valid) row_q <= last_row ? 3'd0 : row_q + 3'd1;
      if (state_q == COL) col_q <= col_q + 2'd1;
      if (out_valid && out_ready) out_q <= out_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) t_q[row_q] <= row_res;
    if (state_q == COL) begin
      for (int i = 0; i < TILE_OUT; i++) begin
        y_q[i][col_q] <= col_res[i];
      end
    end
  end

endmodule

// File: tb/tb_winograd_post_transform_2d.sv
// Directed self-checking bench for winograd_post_transform_2d with hand-computed tiles.
module tb_winograd_post_transform_2d;

  typedef logic [5:0][5:0][63:0] tile_t;
  typedef logic [3:0][3:0][63:0] res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [5:0][63:0] in_row = '0;
  logic             in_ready, out_valid, out_last, busy;
  logic [3:0][63:0] out_row;

  int checks = 0;
  int failures = 0;

  winograd_post_transform_2d #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic tile_t ones_tile();
    tile_t m;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) m[r][c] = 64'd1;
    return m;
  endfunction

  function automatic res_t ones_exp();
    res_t e;
    e[0] = {64'd5, 64'd50, 64'd0, 64'd25};
    e[1] = '0;
    e[2] = {64'd10, 64'd100, 64'd0, 64'd50};
    e[3] = {64'd1, 64'd10, 64'd0, 64'd5};
    return e;
  endfunction

  // Loads six rows; lat counts samples after the row-5 accept until out_valid is seen.
  task automatic send_rows(input tile_t m, input bit hold, output int lat, output bit to);
    int w;
    to = 1'b0;
    in_valid = 1'b1;
    for (int r = 0; r < 6; r++) begin
      in_row = m[r];
      w = 0;
      while (!in_ready && w < 200) begin
        step();
        w++;
      end
      if (!in_ready) to = 1'b1;
      step();
    end
    if (!hold) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    if (!out_valid) to = 1'b1;
  endtask

  task automatic recv_rows(output res_t y, output int lastbad, output int rdy_hi, output bit to);
    int w;
    out_ready = 1'b1;
    lastbad = 0;
    rdy_hi = 0;
    to = 1'b0;
    y = '0;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!out_valid && w < 50) begin
        step();
        w++;
      end
      if (!out_valid) to = 1'b1;
      y[i] = out_row;
      if (out_last !== (i == 3)) lastbad++;
      if (in_ready) rdy_hi++;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, in_ready, out_last, busy} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0100", {out_valid, in_ready, out_last, busy});
    end
    checks++;
    if (out_row !== '0) begin
      failures++;
      $display("FAIL reset_out_row got=%h exp=0", out_row);
    end
    in_valid = 1'b1;
    in_row = '0;
    step();
    in_valid = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL busy_after_row got=%b exp=11", {busy, in_ready});
    end
    do_reset();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_reset got=%b exp=0", busy);
    end
  endtask

  task automatic test_ones();
    res_t y, e;
    int lat, lb, rh;
    bit to1, to2;
    e = ones_exp();
    send_rows(ones_tile(), 1'b0, lat, to1);
    // Row 5 accepted in cycle c; out_valid is high in cycle c+5, the 4th sample after the accept.
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL ones_latency got=%0d exp=4", lat);
    end
    recv_rows(y, lb, rh, to2);
    checks++;
    if ({to1, to2} !== 2'b00) begin
      failures++;
      $display("FAIL ones_timeout got=%b exp=00", {to1, to2});
    end
    checks++;
    if (lb !== 0) begin
      failures++;
      $display("FAIL ones_out_last got=%0d bad rows exp=0", lb);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y[i] !== e[i]) begin
        failures++;
        $display("FAIL ones_row%0d got=%h exp=%h", i, y[i], e[i]);
      end
    end
  endtask

  task automatic test_impulses();
    tile_t m;
    res_t y, e;
    int lat, lb, rh;
    bit to1, to2;
    int c[4] = '{1, 2, 4, 8};
    for (int k = 0; k < 3; k++) begin
      m = '0;
      e = '0;
      if (k == 0) begin
        m[0][0] = 64'd1;
        e[0][0] = 64'd1;
      end else if (k == 1) begin
        m[5][5] = 64'd1;
        e[3][3] = 64'd1;
      end else begin
        m[3][3] = 64'd1;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) e[i][j] = 64'(c[i] * c[j]);
      end
      send_rows(m, 1'b0, lat, to1);
      recv_rows(y, lb, rh, to2);
      checks++;
      if ({to1, to2, lb != 0} !== 3'b000) begin
        failures++;
        $display("FAIL impulse%0d_ctrl got=%b exp=000", k, {to1, to2, lb != 0});
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (y[i] !== e[i]) begin
          failures++;
          $display("FAIL impulse%0d_row%0d got=%h exp=%h", k, i, y[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    tile_t m;
    res_t y, e;
    int lat, lb, rh;
    bit to1, to2;
    m = '0;
    m[3][3] = 64'h4000_0000_0000_0000;
    e = '0;
    e[0][0] = 64'h4000_0000_0000_0000;
    e[0][1] = 64'h8000_0000_0000_0000;
    e[1][0] = 64'h8000_0000_0000_0000;
    send_rows(m, 1'b0, lat, to1);
    recv_rows(y, lb, rh, to2);
    checks++;
    if ({to1, to2} !== 2'b00) begin
      failures++;
      $display("FAIL wrap_timeout got=%b exp=00", {to1, to2});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y[i] !== e[i]) begin
        failures++;
        $display("FAIL wrap_row%0d got=%h exp=%h", i, y[i], e[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t e;
    int lat;
    bit to;
    e = ones_exp();
    send_rows(ones_tile(), 1'b0, lat, to);
    checks++;
    if (to !== 1'b0 || out_row !== e[0]) begin
      failures++;
      $display("FAIL bp_row0 got=%h to=%b exp=%h", out_row, to, e[0]);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, in_ready, out_last} !== 3'b100 || out_row !== e[1]) begin
        failures++;
        $display("FAIL bp_stall%0d got=%b/%h exp=100/%h", k, {out_valid, in_ready, out_last},
                 out_row, e[1]);
      end
      step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== e[i] || out_last !== (i == 3)) begin
        failures++;
        $display("FAIL bp_row%0d got=%b/%h exp=1/%h", i, out_valid, out_row, e[i]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_done got=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    tile_t a, b;
    res_t y, ea, eb;
    int lat, lb, rh;
    bit to1, to2, to3, to4;
    int c[4] = '{1, 2, 4, 8};
    a = ones_tile();
    b = '0;
    b[3][3] = 64'd1;
    ea = ones_exp();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) eb[i][j] = 64'(c[i] * c[j]);
    send_rows(a, 1'b1, lat, to1);
    in_row = b[0];
    recv_rows(y, lb, rh, to2);
    checks++;
    if (rh !== 0) begin
      failures++;
      $display("FAIL b2b_in_ready_during_out got=%0d exp=0", rh);
    end
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_reopen got=%b exp=10", {in_ready, busy});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y[i] !== ea[i]) begin
        failures++;
        $display("FAIL b2b_a_row%0d got=%h exp=%h", i, y[i], ea[i]);
      end
    end
    send_rows(b, 1'b0, lat, to3);
    recv_rows(y, lb, rh, to4);
    checks++;
    if ({to1, to2, to3, to4} !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_timeout got=%b exp=0000", {to1, to2, to3, to4});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y[i] !== eb[i]) begin
        failures++;
        $display("FAIL b2b_b_row%0d got=%h exp=%h", i, y[i], eb[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    tile_t m;
    res_t y, e;
    int lat, lb, rh, seen;
    bit to1, to2, to3;
    m = ones_tile();
    in_valid = 1'b1;
    for (int r = 0; r < 6; r++) begin
      in_row = m[r];
      step();
    end
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL rst_col got=%b exp=010", {out_valid, in_ready, busy});
    end
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_col_discard got=%0d exp=0", seen);
    end
    out_ready = 1'b0;
    send_rows(m, 1'b0, lat, to1);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_out got=%b exp=01", {out_valid, in_ready});
    end
    m = '0;
    m[5][5] = 64'd1;
    e = '0;
    e[3][3] = 64'd1;
    send_rows(m, 1'b0, lat, to2);
    recv_rows(y, lb, rh, to3);
    checks++;
    if ({to1, to2, to3} !== 3'b000) begin
      failures++;
      $display("FAIL rst_timeout got=%b exp=000", {to1, to2, to3});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y[i] !== e[i]) begin
        failures++;
        $display("FAIL rst_after_row%0d got=%h exp=%h", i, y[i], e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_impulses();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
